// File: rtl/semaforo_pkg.sv
// Shared definitions for the two-way traffic-light controller: lamp
// encodings, phase type and default phase durations.
package semaforo_pkg;

    localparam logic [2:0] LAMP_VERDE    = 3'b001;
    localparam logic [2:0] LAMP_AMARELO  = 3'b010;
    localparam logic [2:0] LAMP_VERMELHO = 3'b100;

    localparam logic [7:0] D_VERDE    = 8'd1;
    localparam logic [7:0] D_AMARELO  = 8'd3;
    localparam logic [7:0] D_VERMELHO = 8'd2;

    typedef enum logic [1:0] {
        VERDE,
        AMARELO,
        VERMELHO
    } phase_t;

    // Last counter value of a phase lasting t cycles; a zero duration
    // behaves like a one-cycle phase.
    function automatic logic [7:0] dur_limit(input logic [7:0] t);
        return (t == 8'd0) ? 8'd0 : t - 8'd1;
    endfunction

endpackage

// File: rtl/semaforo_timer.sv
// Phase cycle counter shared by all phases: counts up from zero, flags the
// terminal count and is cleared whenever the phase changes.
module semaforo_timer
    import semaforo_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic [7:0] limit,
    output logic [7:0] cnt,
    output logic       tc
);

    // Counter holds at the limit instead of wrapping if not cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 8'd0;
        end else if (clear) begin
            cnt <= 8'd0;
        end else if (cnt != limit) begin
            cnt <= cnt + 8'd1;
        end
    end

    // Terminal count: this is the last cycle of the current phase.
    always_comb begin
        tc = (cnt == limit);
    end

endmodule

// File: rtl/semaforo.sv
// Two-way traffic-light controller. Light A cycles green/yellow/red with
// programmable durations; light B is decoded from A's phase so that at
// least one light is always red. The button cuts A's green short.
module semaforo
    import semaforo_pkg::*;
#(
    parameter logic [7:0] T_VERDE    = D_VERDE,
    parameter logic [7:0] T_AMARELO  = D_AMARELO,
    parameter logic [7:0] T_VERMELHO = D_VERMELHO
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bt,
    output logic [2:0] A,
    output logic [2:0] B
);

    localparam logic [7:0] LIM_VERDE    = dur_limit(T_VERDE);
    localparam logic [7:0] LIM_AMARELO  = dur_limit(T_AMARELO);
    localparam logic [7:0] LIM_VERMELHO = dur_limit(T_VERMELHO);

    phase_t     phase;
    phase_t     phase_next;
    logic [7:0] cnt;
    logic [7:0] limit;
    logic       tc;
    logic       advance;

    // Select the terminal count of the phase in progress and decide whether
    // this edge leaves the phase (timeout, or button while green).
    always_comb begin
        limit = LIM_VERDE;
        case (phase)
            VERDE:    limit = LIM_VERDE;
            AMARELO:  limit = LIM_AMARELO;
            VERMELHO: limit = LIM_VERMELHO;
            default:  limit = LIM_VERDE;
        endcase
        advance = tc || (bt && (phase == VERDE));
    end

    semaforo_timer u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (advance),
        .limit (limit),
        .cnt   (cnt),
        .tc    (tc)
    );

    // Phase register; reset returns to green on the main road.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= VERDE;
        end else begin
            phase <= phase_next;
        end
    end

    // Next phase follows the fixed green -> yellow -> red rotation.
    always_comb begin
        phase_next = phase;
        if (advance) begin
            case (phase)
                VERDE:    phase_next = AMARELO;
                AMARELO:  phase_next = VERMELHO;
                VERMELHO: phase_next = VERDE;
                default:  phase_next = VERDE;
            endcase
        end
    end

    // Lamp decode: B may only leave red while A is red, and turns yellow in
    // A's final red cycle so B clears before A goes green.
    always_comb begin
        A = LAMP_VERMELHO;
        B = LAMP_VERMELHO;
        case (phase)
            VERDE:   A = LAMP_VERDE;
            AMARELO: A = LAMP_AMARELO;
            VERMELHO: begin
                A = LAMP_VERMELHO;
                B = (cnt == LIM_VERMELHO) ? LAMP_AMARELO : LAMP_VERDE;
            end
            default: A = LAMP_VERMELHO;
        endcase
    end

endmodule

// File: tb/tb_semaforo.sv
// Self-checking bench for semaforo: three instances with different phase
// durations, compared against a position-in-period reference model.
module tb_semaforo;

    logic clk;
    logic rst;
    logic bt0, bt1, bt2;
    logic [2:0] a_o [3];
    logic [2:0] b_o [3];

    int n_assert;
    int n_fail;

    // Reference model: position within the full period of each instance.
    int pos [3];
    int tv  [3];
    int ta  [3];
    int tr  [3];

    semaforo u_d0 (
        .clk (clk), .rst (rst), .bt (bt0), .A (a_o[0]), .B (b_o[0])
    );
    semaforo #(.T_VERDE(8'd5), .T_AMARELO(8'd3), .T_VERMELHO(8'd2)) u_d1 (
        .clk (clk), .rst (rst), .bt (bt1), .A (a_o[1]), .B (b_o[1])
    );
    semaforo #(.T_VERDE(8'd255), .T_AMARELO(8'd3), .T_VERMELHO(8'd1)) u_d2 (
        .clk (clk), .rst (rst), .bt (bt2), .A (a_o[2]), .B (b_o[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int period(input int i);
        return tv[i] + ta[i] + tr[i];
    endfunction

    function automatic logic [2:0] exp_a(input int i);
        if (pos[i] < tv[i]) return 3'b001;
        if (pos[i] < tv[i] + ta[i]) return 3'b010;
        return 3'b100;
    endfunction

    function automatic logic [2:0] exp_b(input int i);
        if (pos[i] < tv[i] + ta[i]) return 3'b100;
        if (pos[i] == period(i) - 1) return 3'b010;
        return 3'b001;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pos[i] = 0;
    endtask

    // One rising edge; models advance with the button levels seen at it.
    task automatic tick();
        logic [2:0] b;
        b = {bt2, bt1, bt0};
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                if (b[i] && pos[i] < tv[i]) pos[i] = tv[i];
                else pos[i] = (pos[i] + 1) % period(i);
            end
        end
        #1;
    endtask

    // Mid-cycle reset pulse (never touches a rising edge).
    task automatic pulse_reset();
        rst = 1'b1;
        model_reset();
        #2;
        rst = 1'b0;
    endtask

    // Safety: one light always red, both always one-hot.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            n_assert++;
            if (!(a_o[i] == 3'b100 || b_o[i] == 3'b100) || !$onehot(a_o[i]) || !$onehot(b_o[i])) begin
                n_fail++;
                $display("FAIL safety inst%0d: A=%b B=%b, required one red and both one-hot", i, a_o[i], b_o[i]);
            end
        end
    end

    task automatic test_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            n_assert++;
            if (a_o[i] !== 3'b001 || b_o[i] !== 3'b100) begin
                n_fail++;
                $display("FAIL reset_initial inst%0d: A=%b B=%b, required A=001 B=100", i, a_o[i], b_o[i]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                n_assert++;
                if (a_o[i] !== 3'b001 || b_o[i] !== 3'b100) begin
                    n_fail++;
                    $display("FAIL reset_hold inst%0d: A=%b B=%b, required A=001 B=100", i, a_o[i], b_o[i]);
                end
            end
        end
    endtask

    task automatic test_default_cycle();
        logic [2:0] tab_a [6];
        logic [2:0] tab_b [6];
        tab_a = '{3'b010, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001};
        tab_b = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
        #3;
        rst = 1'b0;
        model_reset();
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_assert++;
            if (a_o[0] !== tab_a[(k-1)%6] || b_o[0] !== tab_b[(k-1)%6]) begin
                n_fail++;
                $display("FAIL default_cycle edge%0d: A=%b B=%b, required A=%b B=%b",
                         k, a_o[0], b_o[0], tab_a[(k-1)%6], tab_b[(k-1)%6]);
            end
            for (int i = 1; i < 3; i++) begin
                n_assert++;
                if (a_o[i] !== exp_a(i) || b_o[i] !== exp_b(i)) begin
                    n_fail++;
                    $display("FAIL default_model inst%0d edge%0d: A=%b B=%b, required A=%b B=%b",
                             i, k, a_o[i], b_o[i], exp_a(i), exp_b(i));
                end
            end
        end
    endtask

    task automatic test_button();
        logic [2:0] req [5];
        req = '{3'b001, 3'b010, 3'b010, 3'b010, 3'b100};
        pulse_reset();
        for (int k = 1; k <= 5; k++) begin
            bt1 = (k == 2);
            tick();
            n_assert++;
            if (a_o[1] !== req[k-1]) begin
                n_fail++;
                $display("FAIL button_early edge%0d: A=%b, required %b", k, a_o[1], req[k-1]);
            end
        end
        bt1 = 1'b0;
    endtask

    task automatic test_bt_ignored();
        pulse_reset();
        // Pulses that fall strictly between edges must not end green.
        for (int k = 1; k <= 5; k++) begin
            #2 bt1 = 1'b1;
            #2 bt1 = 1'b0;
            tick();
            n_assert++;
            if (a_o[1] !== ((k < 5) ? 3'b001 : 3'b010)) begin
                n_fail++;
                $display("FAIL button_between edge%0d: A=%b, required %b", k, a_o[1], (k < 5) ? 3'b001 : 3'b010);
            end
        end
        // Button held through yellow and red: timing unchanged.
        for (int k = 6; k <= 10; k++) begin
            bt1 = (pos[1] >= tv[1]);
            tick();
            n_assert++;
            if (a_o[1] !== exp_a(1) || b_o[1] !== exp_b(1)) begin
                n_fail++;
                $display("FAIL button_ignored edge%0d: A=%b B=%b, required A=%b B=%b",
                         k, a_o[1], b_o[1], exp_a(1), exp_b(1));
            end
        end
        bt1 = 1'b0;
        n_assert++;
        if (a_o[1] !== 3'b001) begin
            n_fail++;
            $display("FAIL button_ignored_period: A=%b, required 001", a_o[1]);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 200; k++) begin
            bt0 = 1'($urandom_range(0, 1));
            bt1 = 1'($urandom_range(0, 3) == 0);
            bt2 = 1'($urandom_range(0, 1));
            tick();
            for (int i = 0; i < 3; i++) begin
                n_assert++;
                if (a_o[i] !== exp_a(i) || b_o[i] !== exp_b(i)) begin
                    n_fail++;
                    $display("FAIL random inst%0d step%0d: A=%b B=%b, required A=%b B=%b",
                             i, k, a_o[i], b_o[i], exp_a(i), exp_b(i));
                end
            end
        end
        bt0 = 1'b0;
        bt1 = 1'b0;
        bt2 = 1'b0;
    endtask

    task automatic test_async_reset();
        int guard;
        guard = 0;
        while (!(pos[1] >= tv[1] + ta[1] && pos[1] < period(1) - 1) && guard < 50) begin
            tick();
            guard++;
        end
        n_assert++;
        if (a_o[1] !== 3'b100 || b_o[1] !== 3'b001) begin
            n_fail++;
            $display("FAIL async_precond: A=%b B=%b, required A=100 B=001 within 50 cycles", a_o[1], b_o[1]);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            n_assert++;
            if (a_o[i] !== 3'b001 || b_o[i] !== 3'b100) begin
                n_fail++;
                $display("FAIL async_reset inst%0d: A=%b B=%b, required A=001 B=100", i, a_o[i], b_o[i]);
            end
        end
        tick();
        #3;
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_assert++;
            if (a_o[1] !== ((k < 5) ? 3'b001 : 3'b010)) begin
                n_fail++;
                $display("FAIL async_green_len edge%0d: A=%b, required %b", k, a_o[1], (k < 5) ? 3'b001 : 3'b010);
            end
        end
    endtask

    task automatic test_bounds();
        int green_len;
        int red_len;
        pulse_reset();
        green_len = 1;
        while (a_o[2] == 3'b001 && green_len < 300) begin
            tick();
            if (a_o[2] == 3'b001) green_len++;
        end
        n_assert++;
        if (green_len != 255) begin
            n_fail++;
            $display("FAIL bound_green255: green lasted %0d cycles, required 255", green_len);
        end
        tick();
        tick();
        tick();
        red_len = 0;
        while (a_o[2] == 3'b100 && red_len < 10) begin
            red_len++;
            n_assert++;
            if (b_o[2] !== 3'b010) begin
                n_fail++;
                $display("FAIL bound_red1_b: B=%b, required 010", b_o[2]);
            end
            tick();
        end
        n_assert++;
        if (red_len != 1) begin
            n_fail++;
            $display("FAIL bound_red1_len: red lasted %0d cycles, required 1", red_len);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        tv = '{1, 5, 255};
        ta = '{3, 3, 3};
        tr = '{2, 2, 1};
        model_reset();
        rst = 1'b1;
        bt0 = 1'b0;
        bt1 = 1'b0;
        bt2 = 1'b0;
        test_reset();
        test_default_cycle();
        test_button();
        test_bt_ignored();
        test_random();
        test_async_reset();
        test_bounds();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/semaforo.md
Name: semaforo

Overview:
- Two-way traffic-light controller: light A on the main road, light B on the crossing road.
- A cycles green -> yellow -> red, with a programmable cycle count for each phase.
- B is derived from A's phase, so the two lights can never both be non-red.
- Push-button input bt ends A's green phase early.
- Standalone top-level block; its outputs drive the lamp encodings directly.

Parameters:
- T_VERDE, 8'd1: number of clock cycles A stays green (legal 1..255).
- T_AMARELO, 8'd3: number of clock cycles A stays yellow (legal 1..255).
- T_VERMELHO, 8'd2: number of clock cycles A stays red (legal 1..255).
- A value of 0 is treated as 1.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- bt   input  1  request button, active-high level, sampled synchronously on rising clk.
- A    output 3  light A lamps, one-hot: 3'b001 green, 3'b010 yellow, 3'b100 red.
- B    output 3  light B lamps, same encoding as A.

Behaviour:
- Internal state:
  - phase register with states VERDE, AMARELO, VERMELHO;
  - 8-bit cycle counter cnt.
- Reset (rst=1, asynchronous, dominant over everything):
  - phase=VERDE, cnt=0, so A=3'b001 and B=3'b100 immediately.
  - Applies the same way mid-operation and holds while rst is high.
- Rising clk with rst=0, where T = duration of the current phase:
  - if cnt == T-1: advance phase (VERDE->AMARELO->VERMELHO->VERDE) and set cnt=0;
  - else: cnt = cnt+1.
- Each phase therefore lasts exactly T cycles. Full period with defaults is 1+3+2 = 6 cycles.
- Button:
  - If bt=1 at a rising edge while phase=VERDE, phase goes to AMARELO and cnt=0 at that edge, whatever the remaining count.
  - bt is ignored in AMARELO and VERMELHO. There is no latching: a pulse that does not cover a rising edge has no effect.
  - bt held high continuously limits green to 1 cycle per period.
- Output mapping (combinational from registered state, no extra latency):
  - A follows phase: VERDE=001, AMARELO=010, VERMELHO=100.
  - B=100 (red) while A is green or yellow.
  - During A red: B=001 (green) while cnt < T_VERMELHO-1, and B=010 (yellow) in the last red cycle (cnt == T_VERMELHO-1).
  - With T_VERMELHO=1, B shows yellow only.
- Safety invariant: at every cycle at least one of A, B equals 3'b100. Outputs are always exactly one-hot.
- The counter never exceeds T-1 and never wraps; the 8-bit width suffices for T up to 255.

Decomposition:
- Shared package:
  - lamp encodings LAMP_VERDE=3'b001, LAMP_AMARELO=3'b010, LAMP_VERMELHO=3'b100;
  - phase enum typedef (VERDE, AMARELO, VERMELHO);
  - default duration constants 1/3/2.
- One natural sub-module, semaforo_timer: 8-bit counter with clear/load and a terminal-count flag, shared across phases.
- The FSM and output decode stay in the top level.

Test Plan:
- Reset: rst=1 at t=0 -> A=001, B=100 before any clock edge; outputs hold through edges while rst=1.
- Default cycle, bt=0, rst released before edge 1:
  - after edge 1: A=010, B=100; edges 2-3: unchanged;
  - after edge 4: A=100, B=001; after edge 5: A=100, B=010;
  - after edge 6: A=001, B=100; repeats with period 6.
- Button early exit, T_VERDE=5: bt=1 at edge 2 only -> A=010 after edge 2 (not edge 5); yellow then lasts 3 cycles.
- Button ignored, T_VERDE=5:
  - bt pulses between edges -> green still lasts 5 cycles;
  - bt=1 during yellow or red -> timing unchanged.
- Async reset mid-operation: assert rst between edges while A=100/B=001 -> A=001, B=100 immediately; after release, green lasts the full T_VERDE cycles.
- Bounds and safety: T_VERMELHO=1 -> B=010 for the single red cycle, never 001; T=255 -> phase lasts exactly 255 cycles; assert every cycle that A==100 or B==100.
